// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
//
// Registered ShiftRows / InvShiftRows stage for the Rijndael round datapath.
// Supports block sizes of NB = 4..8 columns. Each beat selects the forward or
// the inverse permutation. The permutation is applied combinationally on the
// input side. The result is captured in a 2-entry skid buffer (head + skid).
// This sustains one beat per cycle, and every output comes straight from a
// flop.
//
// Parameters
//   NB        state columns, 4..8 (other values stop elaboration)
//   TAG_W     width of the sideband tag carried with each beat
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   InValid    input beat valid
//   InReady    input beat accepted when InValid && InReady
//   InInv      1 = InvShiftRows, 0 = ShiftRows (sampled with the beat)
//   InTag      sideband tag, passed through unchanged
//   InState    state; byte k = 4*c + r occupies bits [8k:8k+7]
//   OutValid   output beat valid
//   OutReady   downstream accept
//   OutState   permuted state (head entry)
//   OutTag     tag of the head entry
//   BeatCount  16-bit wrapping accepted-beat counter
//              (only when SHIFTROWS_CNT_EN is defined)
//
// Optional feature macro: SHIFTROWS_CNT_EN
// -----------------------------------------------------------------------------
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic               InInv,
    input  logic [TAG_W-1:0]   InTag,
    input  logic [0:32*NB-1]   InState,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [0:32*NB-1]   OutState,
    output logic [TAG_W-1:0]   OutTag
`ifdef SHIFTROWS_CNT_EN
    ,
    output logic [15:0]        BeatCount
`endif
);

    localparam int BYTE_W = 8;
    localparam int ST_W   = 32 * NB;

    if ((NB < 4) || (NB > 8)) begin : g_nb_check
        $error("shift_rows_pipe: NB must be in the range 4..8");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // Row rotation amount. Wide blocks spread rows 2/3 further apart.
    function automatic int row_offset(input int r);
        int off;
        case (r)
            32'sd0:  off = 32'sd0;
            32'sd1:  off = 32'sd1;
            32'sd2:  off = (NB == 32'sd8) ? 32'sd3 : 32'sd2;
            32'sd3:  off = (NB >= 32'sd7) ? 32'sd4 : 32'sd3;
            default: off = 32'sd0;
        endcase
        return off;
    endfunction

    // Source column feeding output column c of row r.
    function automatic int src_col(input int c, input int r, input logic inv);
        int col;
        if (inv) begin
            col = (c + NB - row_offset(r)) % NB;
        end else begin
            col = (c + row_offset(r)) % NB;
        end
        return col;
    endfunction

    // First bit index of byte (column c, row r) in the ascending state vector.
    function automatic int byte_pos(input int c, input int r);
        return 32'sd8 * (32'sd4 * c + r);
    endfunction

    buf_state_t         state_r;
    buf_state_t         state_nxt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [0:ST_W-1]    perm_s;
    logic [0:ST_W-1]    head_state_r;
    logic [TAG_W-1:0]   head_tag_r;
    logic [0:ST_W-1]    skid_state_r;
    logic [TAG_W-1:0]   skid_tag_r;
    logic               accept_s;
    logic               pop_s;
    logic               head_load_in_s;
    logic               head_load_skid_s;
    logic               skid_load_s;

    // Both handshakes depend only on registered flags, never on the partner's input.
    assign accept_s = InValid & in_ready_r;
    assign pop_s    = out_valid_r & OutReady;

    // Input-side row permutation; the buffer stores already-permuted state.
    always_comb begin
        perm_s = '0;
        for (int c = 32'sd0; c < NB; c++) begin
            for (int r = 32'sd0; r < 32'sd4; r++) begin
                if (InInv) begin
                    perm_s[byte_pos(c, r) +: BYTE_W] =
                        InState[byte_pos(src_col(c, r, 1'b1), r) +: BYTE_W];
                end else begin
                    perm_s[byte_pos(c, r) +: BYTE_W] =
                        InState[byte_pos(src_col(c, r, 1'b0), r) +: BYTE_W];
                end
            end
        end
    end

    // Buffer occupancy FSM: next state and data-load strobes.
    always_comb begin
        state_nxt_s      = state_r;
        head_load_in_s   = 1'b0;
        head_load_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_nxt_s    = ONE;
                    head_load_in_s = 1'b1;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && pop_s) begin
                    // Head leaves and the new beat replaces it in the same edge.
                    state_nxt_s    = ONE;
                    head_load_in_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s = TWO;
                    skid_load_s = 1'b1;
                end else if (pop_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            TWO: begin
                if (pop_s) begin
                    state_nxt_s      = ONE;
                    head_load_skid_s = 1'b1;
                end else begin
                    state_nxt_s = TWO;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != EMPTY);
            in_ready_r  <= (state_nxt_s != TWO);
        end
    end

    // Head entry: loaded from the input or promoted from the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_state_r <= '0;
            head_tag_r   <= '0;
        end else if (head_load_in_s) begin
            head_state_r <= perm_s;
            head_tag_r   <= InTag;
        end else if (head_load_skid_s) begin
            head_state_r <= skid_state_r;
            head_tag_r   <= skid_tag_r;
        end else begin
            head_state_r <= head_state_r;
            head_tag_r   <= head_tag_r;
        end
    end

    // Skid entry: catches the one beat accepted while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_state_r <= '0;
            skid_tag_r   <= '0;
        end else if (skid_load_s) begin
            skid_state_r <= perm_s;
            skid_tag_r   <= InTag;
        end else begin
            skid_state_r <= skid_state_r;
            skid_tag_r   <= skid_tag_r;
        end
    end

    assign InReady  = in_ready_r;
    assign OutValid = out_valid_r;
    assign OutState = head_state_r;
    assign OutTag   = head_tag_r;

`ifdef SHIFTROWS_CNT_EN
    logic [15:0] beat_count_r;

    // Accepted-beat counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_r <= 16'd0;
        end else if (accept_s) begin
            beat_count_r <= beat_count_r + 16'd1;
        end else begin
            beat_count_r <= beat_count_r;
        end
    end

    assign BeatCount = beat_count_r;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_rows_pipe
//
// Self-checking bench for shift_rows_pipe. It uses an NB=4 instance for the
// handshake/buffer behaviour and an NB=8 instance for the wide-block offsets.
// Expected data comes from a row-rotation model built on byte queues.
// Occupancy is tracked with a queue of expected beats.
// -----------------------------------------------------------------------------
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n;

    // Clock generator, 10 time-unit period.
    always #5 clk = ~clk;

    logic         iv4, ir4, inv4, ov4, or4;
    logic [3:0]   tag4, otag4;
    logic [0:127] st4, ost4;

    logic         iv8, ir8, inv8, ov8, or8;
    logic [3:0]   tag8, otag8;
    logic [0:255] st8, ost8;

`ifdef SHIFTROWS_CNT_EN
    logic [15:0]  bc4, bc8;
`endif

    shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .InValid  (iv4),
        .InReady  (ir4),
        .InInv    (inv4),
        .InTag    (tag4),
        .InState  (st4),
        .OutValid (ov4),
        .OutReady (or4),
        .OutState (ost4),
        .OutTag   (otag4)
`ifdef SHIFTROWS_CNT_EN
        ,
        .BeatCount(bc4)
`endif
    );

    shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .InValid  (iv8),
        .InReady  (ir8),
        .InInv    (inv8),
        .InTag    (tag8),
        .InState  (st8),
        .OutValid (ov8),
        .OutReady (or8),
        .OutState (ost8),
        .OutTag   (otag8)
`ifdef SHIFTROWS_CNT_EN
        ,
        .BeatCount(bc8)
`endif
    );

    typedef struct packed {
        logic [0:127] st;
        logic [3:0]   tag;
    } beat_t;

    beat_t exp_q[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;
    int    acc_cnt   = 0;

    // Reference ShiftRows: each row is a byte queue rotated by its offset.
    function automatic logic [0:255] ref_shift(input int nb, input bit inv, input logic [0:255] s);
        logic [0:255] d;
        int           offs[4];
        logic [7:0]   row[$];
        d = '0;
        case (nb)
            7:       offs = '{0, 1, 2, 4};
            8:       offs = '{0, 1, 3, 4};
            default: offs = '{0, 1, 2, 3};
        endcase
        for (int r = 0; r < 4; r++) begin
            row.delete();
            for (int c = 0; c < nb; c++) row.push_back(s[8*(4*c+r) +: 8]);
            for (int k = 0; k < offs[r]; k++) begin
                if (!inv) row.push_back(row.pop_front());
                else      row.push_front(row.pop_back());
            end
            for (int c = 0; c < nb; c++) d[8*(4*c+r) +: 8] = row[c];
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One cycle on the NB=4 instance with occupancy, pop-order and stall checks.
    task automatic cycle4(input bit iv, input logic [0:127] st, input bit inv,
                          input logic [3:0] tag, input bit ordy, output bit acc);
        logic [0:255] m;
        beat_t        e;
        bit           pop;
        bit           hold;
        logic [0:127] hs;
        logic [3:0]   ht;
        iv4  = iv;
        st4  = st;
        inv4 = inv;
        tag4 = tag;
        or4  = ordy;
        check("in_ready", ir4, exp_q.size() < 2);
        check("out_valid", ov4, exp_q.size() != 0);
        acc  = iv && ir4;
        pop  = ov4 && ordy;
        hold = ov4 && !ordy;
        hs   = ost4;
        ht   = otag4;
        if (pop && exp_q.size() > 0) begin
            check("pop_state", ost4, exp_q[0].st);
            check("pop_tag", otag4, exp_q[0].tag);
            void'(exp_q.pop_front());
        end
        if (acc) begin
            m     = ref_shift(4, inv, {st, 128'h0});
            e.st  = m[0:127];
            e.tag = tag;
            exp_q.push_back(e);
            acc_cnt++;
        end
        step();
        if (hold) begin
            check("stall_valid", ov4, 1'b1);
            check("stall_state", ost4, hs);
            check("stall_tag", otag4, ht);
        end
    endtask

    logic [0:127] inc4;
    logic [0:255] inc8;
    logic [0:255] sav8;
    logic [0:127] rs;
    logic [0:127] sst[8];
    bit           a;
    bit           v;
    int           sent;
    int           b;
    int           low_cnt;

    initial begin
        for (int k = 0; k < 16; k++) inc4[8*k +: 8] = 8'(k);
        for (int k = 0; k < 32; k++) inc8[8*k +: 8] = 8'(k);

        rst_n = 1'b0;
        iv4 = 1'b0; inv4 = 1'b0; tag4 = 4'h0; st4 = '0; or4 = 1'b0;
        iv8 = 1'b0; inv8 = 1'b0; tag8 = 4'h0; st8 = '0; or8 = 1'b1;
        #12;
        check("rst4_out_valid", ov4, 1'b0);
        check("rst4_in_ready", ir4, 1'b1);
        check("rst4_out_state", ost4, 128'h0);
        check("rst4_out_tag", otag4, 4'h0);
        check("rst8_out_valid", ov8, 1'b0);
        check("rst8_in_ready", ir8, 1'b1);
        check("rst8_out_state", ost8, 256'h0);
`ifdef SHIFTROWS_CNT_EN
        check("rst4_beat_count", bc4, 16'h0);
`endif
        rst_n = 1'b1;

        // NB=4 directed vectors; first beat lands on the first edge after reset.
        cycle4(1'b1, inc4, 1'b0, 4'h1, 1'b1, a);
        check("nb4_fwd_const", ost4, 128'h00050A0F04090E03080D02070C01060B);
        cycle4(1'b1, inc4, 1'b1, 4'h2, 1'b1, a);
        check("nb4_inv_const", ost4, 128'h000D0A0704010E0B0805020F0C090603);
        cycle4(1'b1, 128'h00050A0F04090E03080D02070C01060B, 1'b1, 4'h3, 1'b1, a);
        check("nb4_roundtrip", ost4, inc4);
        cycle4(1'b0, '0, 1'b0, 4'h0, 1'b1, a);

        // NB=8 directed vectors.
        iv8 = 1'b1; inv8 = 1'b0; tag8 = 4'h5; st8 = inc8;
        step();
        check("nb8_fwd_valid", ov8, 1'b1);
        check("nb8_fwd_col0", ost8[0:31], 32'h00050E13);
        check("nb8_fwd_full", ost8, ref_shift(8, 1'b0, inc8));
        check("nb8_fwd_tag", otag8, 4'h5);
        sav8 = ost8;
        inv8 = 1'b1; tag8 = 4'h6; st8 = sav8;
        step();
        check("nb8_roundtrip", ost8, inc8);
        check("nb8_inv_tag", otag8, 4'h6);
        for (int i = 0; i < 6; i++) begin
            st8  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            inv8 = 1'($urandom_range(1));
            tag8 = 4'(i);
            sav8 = st8;
            step();
            check("nb8_rand_state", ost8, ref_shift(8, inv8, sav8));
            check("nb8_rand_tag", otag8, 4'(i));
        end
        iv8 = 1'b0;
        step();
        check("nb8_drained", ov8, 1'b0);

        // NB=4 random traffic with random backpressure.
        sent = 0;
        for (int cyc = 0; cyc < 2000 && (sent < 60 || exp_q.size() != 0); cyc++) begin
            v  = (sent < 60) && ($urandom_range(3) != 0);
            rs = {$urandom, $urandom, $urandom, $urandom};
            cycle4(v, rs, 1'($urandom_range(1)), 4'($urandom_range(15)),
                   $urandom_range(3) != 0, a);
            if (a) sent++;
        end
        check("rand_drain", exp_q.size(), 0);
        check("rand_sent", sent, 60);

        // Eight tagged beats, alternating direction, stalled in cycles 2..4.
        for (int i = 0; i < 8; i++) sst[i] = {$urandom, $urandom, $urandom, $urandom};
        b = 0;
        low_cnt = 0;
        for (int cyc = 0; cyc < 60 && (b < 8 || exp_q.size() != 0); cyc++) begin
            if (ir4 == 1'b0) low_cnt++;
            cycle4(b < 8, sst[(b < 8) ? b : 0], 1'(b), 4'(b), !(cyc >= 2 && cyc <= 4), a);
            if (a) b++;
        end
        check("stream_beats", b, 8);
        check("stream_drain", exp_q.size(), 0);
        check("stream_ready_low_cycles", low_cnt, 3);

        // Fill both entries, then reset asynchronously in mid-cycle.
        cycle4(1'b1, sst[0], 1'b0, 4'hA, 1'b0, a);
        cycle4(1'b1, sst[1], 1'b1, 4'hB, 1'b0, a);
        check("two_in_ready", ir4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", ov4, 1'b0);
        check("midrst_in_ready", ir4, 1'b1);
        check("midrst_out_state", ost4, 128'h0);
        check("midrst_out_tag", otag4, 4'h0);
`ifdef SHIFTROWS_CNT_EN
        check("midrst_beat_count", bc4, 16'h0);
`endif
        exp_q.delete();
        acc_cnt = 0;
        #1;
        rst_n = 1'b1;
        cycle4(1'b1, sst[2], 1'b1, 4'hC, 1'b1, a);
        check("post_rst_out_state", ost4, ref_shift(4, 1'b1, {sst[2], 128'h0}) >> 128);
        cycle4(1'b0, '0, 1'b0, 4'h0, 1'b1, a);
        check("post_rst_drain", exp_q.size(), 0);

`ifdef SHIFTROWS_CNT_EN
        check("beat_count_track", bc4, 16'(acc_cnt));
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        iv4 = 1'b1; or4 = 1'b1; st4 = inc4; inv4 = 1'b0;
        for (int i = 0; i < 65537; i++) step();
        iv4 = 1'b0;
        check("beat_count_wrap", bc4, 16'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Parametrised, registered ShiftRows/InvShiftRows unit for the Rijndael round datapath. Supports block sizes Nb = 4..8 columns and selects forward or inverse permutation per beat. It sits between SubBytes/InvSubBytes and MixColumns/InvMixColumns in the iterative round core. Valid/ready handshakes on both sides and a 2-entry skid buffer give one beat per cycle with fully registered outputs.

## Interface
- NB, 4, state columns; legal 4..8; any other value is a compile-time error.
- TAG_W, 4, width of a sideband tag carried alongside each beat, e.g. the round index.
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- InValid  in  1  input beat valid.
- InReady  out  1  input beat accepted when InValid && InReady.
- InInv  in  1  1 = InvShiftRows, 0 = ShiftRows; sampled with the beat.
- InTag  in  TAG_W  sideband tag; passed through unchanged.
- InState  in  [0:32*NB-1]  state; byte k = 4*c + r occupies bits [8k:8k+7].
- OutValid  out  1  output beat valid.
- OutReady  in  1  downstream accept.
- OutState  out  [0:32*NB-1]  permuted state.
- OutTag  out  TAG_W  tag of the output beat.
- BeatCount  out  16  accepted-beat counter; present only with SHIFTROWS_CNT_EN.

## Operation
- Row offsets s(r), r = 0..3: NB 4/5/6 → 0,1,2,3; NB 7 → 0,1,2,4; NB 8 → 0,1,3,4.
- Forward: out[r][c] = in[r][(c + s(r)) mod NB]. Inverse: out[r][c] = in[r][(c − s(r)) mod NB]. Row 0 is never moved.
- The permutation is applied combinationally at the input. The buffer stores permuted state plus tag, so the output path has no logic after the registers.
- Buffer FSM with states EMPTY, ONE, TWO:
  - EMPTY: accept → ONE.
  - ONE: accept without pop → TWO; pop without accept → EMPTY; accept and pop together → ONE, with the new beat moving into the head.
  - TWO: pop → ONE, with the skid entry moving into the head. No accept is possible in TWO.
- InReady = (state != TWO). It is a registered-state decode with no combinational path from OutReady.
- OutValid = (state != EMPTY). OutState/OutTag always show the head entry. They must hold stable while OutValid && !OutReady.
- Beats leave in the order they were accepted. InInv may change on every beat.
- With SHIFTROWS_CNT_EN, BeatCount increments on each accepted beat and wraps from 0xFFFF to 0x0000.

## Timing
- Reset values (asynchronous, on rst_n low): state EMPTY, OutValid 0, InReady 1, OutState all 0, OutTag 0, BeatCount 0.
- Reset asserted mid-operation discards all buffered beats immediately. The first accept after reset deasserts is allowed on the first rising edge with rst_n high.
- Latency: a beat accepted at edge N is presented on OutValid after edge N (visible in cycle N+1) if the buffer was empty. It is later only if older beats are queued.
- Throughput: 1 beat/cycle with OutReady held high.
- Backpressure: when OutReady drops, at most 1 further beat is accepted (skid entry), then InReady goes low the following cycle.
- Handshake rules: no combinational path from InValid to OutValid, or from OutReady to InReady. Data/tag must not change while OutValid && !OutReady.

## Configuration
- SHIFTROWS_CNT_EN defined: BeatCount port and its 16-bit wrapping counter are built. Intended for debug and throughput checks.
- SHIFTROWS_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- NB=4, InInv=0, InState bytes 00..0F, OutReady=1 → one cycle later OutState = 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B.
- NB=4, InInv=1, same input → OutState = 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. Forward then inverse returns 00..0F.
- NB=8, InInv=0, bytes 00..1F → first output column 00 05 0E 13. Inverse of that output restores 00..1F.
- Stream 8 beats with tags 0..7 and alternating InInv, holding OutReady low for cycles 2–4 → InReady low exactly while 2 entries are held. All 8 beats emerge in order with correct tags and no loss or duplication; output is stable while stalled.
- Assert rst_n low with state TWO → OutValid 0, InReady 1, OutState 0 immediately. The next beat after release emerges normally.
- With SHIFTROWS_CNT_EN, accept 65537 beats → BeatCount = 1 after wrap. Without the macro, the build has no BeatCount port.
